// File: rtl/counter_arbiter.sv
// Round-robin owner of a shared up-counter: grants one requester a 0..len run, then pulses its done.
// Latency: req->grant 1 cycle, all outputs registered; hold freezes the count, dropping req aborts the run.
module counter_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] len,
  input  logic                  hold,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [CNT_W-1:0]      val,
  output logic [NREQ-1:0]       done
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    rr, rr_nxt;
  logic [IW-1:0]    win, win_nxt, win_inc;
  logic [IW-1:0]    pick, idx;
  logic             pick_vld;
  logic [CNT_W-1:0] lim, lim_nxt, pick_len;
  logic [CNT_W-1:0] val_nxt;
  logic [NREQ-1:0]  grant_nxt, done_nxt;
  logic             busy_nxt;

  // First requester at or after rr, walking upward with wrap.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = rr;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_vld && req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
      idx = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    pick_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) pick_len = len[i*CNT_W +: CNT_W];
    end
  end

  assign win_inc = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    win_nxt   = win;
    lim_nxt   = lim;
    val_nxt   = val;
    grant_nxt = grant;
    busy_nxt  = busy;
    done_nxt  = '0;
    case (state)
      ST_IDLE: begin
        val_nxt   = '0;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        if (pick_vld) begin
          state_nxt       = ST_RUN;
          win_nxt         = pick;
          lim_nxt         = pick_len;
          grant_nxt[pick] = 1'b1;
          busy_nxt        = 1'b1;
        end
      end
      ST_RUN: begin
        // An abandoned request wins over hold and terminal count.
        if (!req[win]) begin
          state_nxt = ST_IDLE;
          rr_nxt    = win_inc;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          val_nxt   = '0;
        end else if (!hold) begin
          if (val == lim) begin
            state_nxt = ST_DONE;
            done_nxt  = grant;
          end else begin
            val_nxt = val + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        rr_nxt    = win_inc;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        val_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        val_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      rr    <= '0;
      win   <= '0;
      lim   <= '0;
      val   <= '0;
      grant <= '0;
      busy  <= 1'b0;
      done  <= '0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      win   <= win_nxt;
      lim   <= lim_nxt;
      val   <= val_nxt;
      grant <= grant_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

endmodule
